mgia_video_fetch: RTL and testbench

- Video fetch stage directly upstream of the MGIA pixel shifter.
- On each horizontal-start pulse from the CRTC timing logic, the block reads one scanline of monochrome framebuffer words over a classic Wishbone B3 master port.
- Fetched words go into a ping-pong line buffer. The shifter reads the other bank by word address while the next line is being fetched.

---
 rtl/mgia_pkg.sv | 16 +
 rtl/mgia_line_ram.sv | 35 +++
 rtl/mgia_video_fetch.sv | 175 +++++++++++++++++
 tb/tb_mgia_video_fetch.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mgia_pkg.sv
// Shared constants and state encoding for the MGIA video fetch stage.
package mgia_pkg;

    // Default geometry: 640 px at 1 bpp, 16-bit framebuffer words.
    localparam int MGIA_WORDS_PER_LINE = 40;
    localparam int MGIA_ADR_WIDTH      = 23;
    localparam int MGIA_LB_AW          = 6;
    localparam int MGIA_DATA_WIDTH     = 16;

    // Line fetch controller states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/mgia_line_ram.sv
// Ping-pong line buffer: two banks of 2**LB_AW x 16 words in one simple
// dual-port RAM. The bank select is the top address bit on both ports.
// Synchronous write port and synchronous (registered) read port so the
// array maps onto a single block RAM.
module mgia_line_ram
    import mgia_pkg::*;
#(
    parameter int LB_AW = MGIA_LB_AW,
    parameter int DW    = MGIA_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             we,
    input  logic [LB_AW:0]   waddr,
    input  logic [DW-1:0]    wdata,
    input  logic [LB_AW:0]   raddr,
    output logic [DW-1:0]    rdata
);

    logic [DW-1:0] mem [2**(LB_AW+1)];

    // Write port: one word per acknowledged bus read.
    // NOTE: the array has no reset; block RAMs cannot be cleared in one
    // cycle, and any reset branch here would force it into flip-flops.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: registered output, one cycle of latency.
    always_ff @(posedge clk) begin
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/mgia_video_fetch.sv
// MGIA video fetch: on every HSTART_I pulse, reads one scanline of
// framebuffer words over a classic Wishbone B3 master port into the write
// bank of a ping-pong line buffer while the pixel shifter reads the other
// (display) bank.
// Optional build macro: MGIA_FETCH_DOUBLESCAN_EN -- fetch only every second
// HSTART_I so each fetched line is displayed twice.
module mgia_video_fetch
    import mgia_pkg::*;
#(
    parameter int WORDS_PER_LINE = MGIA_WORDS_PER_LINE,
    parameter int ADR_WIDTH      = MGIA_ADR_WIDTH,
    parameter int LB_AW          = MGIA_LB_AW
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,
    input  logic [ADR_WIDTH-1:0] FB_BASE_I,
    input  logic                 VSTART_I,
    input  logic                 HSTART_I,
    output logic [ADR_WIDTH-1:0] ADR_O,
    output logic                 CYC_O,
    output logic                 STB_O,
    input  logic                 ACK_I,
    input  logic [15:0]          DAT_I,
    input  logic [LB_AW-1:0]     LB_ADR_I,
    output logic [15:0]          LB_DAT_O,
    output logic                 UNDERRUN_O
);

    localparam logic [ADR_WIDTH-1:0] LINE_STRIDE = ADR_WIDTH'(WORDS_PER_LINE);
    localparam logic [LB_AW-1:0]     LAST_WORD   = LB_AW'(WORDS_PER_LINE - 1);

    fetch_state_t          state_q, state_d;
    logic [LB_AW-1:0]      cnt_q, cnt_d;
    logic [ADR_WIDTH-1:0]  line_ptr_q, line_ptr_d;
    logic [ADR_WIDTH-1:0]  adr_q, adr_d;
    logic                  wbank_q, wbank_d;
    logic                  cyc_q, cyc_d;
    logic                  underrun_q, underrun_d;
    logic                  ram_we;
    logic [ADR_WIDTH-1:0]  start_base;
    logic                  start;
    logic                  rd_valid_q;
    logic [15:0]           ram_q;

`ifdef MGIA_FETCH_DOUBLESCAN_EN
    logic parity_q, parity_d, parity_eff;

    // Line parity: VSTART_I clears it before the HSTART_I of the same cycle
    // is considered; odd lines start no fetch and keep the displayed bank.
    always_comb begin
        parity_eff = VSTART_I ? 1'b0 : parity_q;
        parity_d   = HSTART_I ? ~parity_eff : parity_eff;
        start      = HSTART_I & ~parity_eff;
    end

    // Parity register.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`else
    assign start = HSTART_I;
`endif

    // Next-state and datapath: frame restart, word acceptance, line start.
    // NOTE: every signal gets a default first so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        line_ptr_d = line_ptr_q;
        adr_d      = adr_q;
        wbank_d    = wbank_q;
        cyc_d      = cyc_q;
        underrun_d = underrun_q;
        ram_we     = 1'b0;
        start_base = line_ptr_q;

        if (VSTART_I) begin
            // New frame: abort any burst and rewind to the framebuffer base.
            state_d    = ST_IDLE;
            cyc_d      = 1'b0;
            line_ptr_d = FB_BASE_I;
            underrun_d = 1'b0;
            start_base = FB_BASE_I;
        end else if (state_q == ST_FETCH) begin
            if (start) begin
                // Previous line never finished: skip to the next line start
                // so the frame stays aligned.
                underrun_d = 1'b1;
                start_base = line_ptr_q + LINE_STRIDE;
            end else if (ACK_I) begin
                ram_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                adr_d  = line_ptr_q + ADR_WIDTH'(cnt_q) + ADR_WIDTH'(1);
                if (cnt_q == LAST_WORD) begin
                    state_d    = ST_IDLE;
                    cyc_d      = 1'b0;
                    line_ptr_d = line_ptr_q + LINE_STRIDE;
                end
            end
        end

        if (start) begin
            state_d    = ST_FETCH;
            cnt_d      = '0;
            line_ptr_d = start_base;
            adr_d      = start_base;
            wbank_d    = ~wbank_q;
            cyc_d      = 1'b1;
        end
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value at the same edge regardless of statement order.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: bus outputs, counters, bank select, sticky flag.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            cnt_q      <= '0;
            line_ptr_q <= '0;
            adr_q      <= '0;
            wbank_q    <= 1'b0;
            cyc_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            line_ptr_q <= line_ptr_d;
            adr_q      <= adr_d;
            wbank_q    <= wbank_d;
            cyc_q      <= cyc_d;
            underrun_q <= underrun_d;
        end
    end

    // Shifter read qualifier: addresses past the end of the line read as 0.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= (32'(LB_ADR_I) < WORDS_PER_LINE);
        end
    end

    mgia_line_ram #(
        .LB_AW (LB_AW),
        .DW    (16)
    ) u_line_ram (
        .clk   (CLK_I),
        .we    (ram_we),
        .waddr ({wbank_q, cnt_q}),
        .wdata (DAT_I),
        .raddr ({~wbank_q, LB_ADR_I}),
        .rdata (ram_q)
    );

    // Single-read classic cycles: strobe follows the cycle signal.
    assign ADR_O      = adr_q;
    assign CYC_O      = cyc_q;
    assign STB_O      = cyc_q;
    assign UNDERRUN_O = underrun_q;
    assign LB_DAT_O   = rd_valid_q ? ram_q : 16'h0000;

endmodule

// File: tb/tb_mgia_video_fetch.sv
// Self-checking bench for mgia_video_fetch. A Wishbone slave model returns
// the low 16 address bits as data; expected bus addresses and line-buffer
// read data are queued when stimulus is issued and popped as the DUT
// produces them. Inputs change on the falling edge; outputs sampled there.
module tb_mgia_video_fetch;

    localparam int WPL = 40;
    localparam int AW  = 23;
    localparam int LAW = 6;

    logic            clk = 1'b0;
    logic            RST_I = 1'b1;
    logic [AW-1:0]   FB_BASE_I = '0;
    logic            VSTART_I = 1'b0;
    logic            HSTART_I = 1'b0;
    logic [AW-1:0]   ADR_O;
    logic            CYC_O;
    logic            STB_O;
    logic            ACK_I = 1'b0;
    logic [15:0]     DAT_I = '0;
    logic [LAW-1:0]  LB_ADR_I = '0;
    logic [15:0]     LB_DAT_O;
    logic            UNDERRUN_O;

    int n_cmp = 0;
    int n_err = 0;

    logic [AW-1:0] exp_adr_q [$];
    logic [15:0]   exp_lb_q  [$];

    always #10 clk = ~clk;

    mgia_video_fetch #(
        .WORDS_PER_LINE (WPL),
        .ADR_WIDTH      (AW),
        .LB_AW          (LAW)
    ) dut (
        .CLK_I      (clk),
        .RST_I      (RST_I),
        .FB_BASE_I  (FB_BASE_I),
        .VSTART_I   (VSTART_I),
        .HSTART_I   (HSTART_I),
        .ADR_O      (ADR_O),
        .CYC_O      (CYC_O),
        .STB_O      (STB_O),
        .ACK_I      (ACK_I),
        .DAT_I      (DAT_I),
        .LB_ADR_I   (LB_ADR_I),
        .LB_DAT_O   (LB_DAT_O),
        .UNDERRUN_O (UNDERRUN_O)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached (got no finish, required finish)");
        $fatal(1, "watchdog");
    end

    // One-cycle pulse on VSTART_I and/or HSTART_I; returns on the falling
    // edge after the DUT has sampled it.
    task automatic pulse(input logic v, input logic h);
        @(negedge clk);
        VSTART_I = v;
        HSTART_I = h;
        @(negedge clk);
        VSTART_I = 1'b0;
        HSTART_I = 1'b0;
    endtask

    // Queue the addresses of n consecutive words starting at base.
    task automatic push_adrs(input logic [AW-1:0] base, input int n);
        logic [AW-1:0] a;
        a = base;
        for (int i = 0; i < n; i++) begin
            exp_adr_q.push_back(a);
            a = a + 1'b1;
        end
    endtask

    // Wishbone slave: acknowledge n reads, one every `period` strobed
    // cycles. Checks each address against the queue and that the address
    // holds still during wait states. With done=1 also checks the cycle
    // ends right after the last acknowledge.
    task automatic run_fetch(input int n, input int period, input bit done, input string tag);
        int            acks;
        int            wait_cnt;
        int            guard;
        logic [AW-1:0] held;
        bit            have_held;
        logic [AW-1:0] exp;
        acks = 0;
        wait_cnt = 0;
        guard = 0;
        have_held = 1'b0;
        held = '0;
        while (acks < n && guard < 2000) begin
            @(negedge clk);
            guard++;
            ACK_I = 1'b0;
            if (CYC_O && STB_O) begin
                if (have_held) begin
                    n_cmp++;
                    if (ADR_O !== held) begin
                        n_err++;
                        $display("FAIL %s adr_stable: got %h required %h", tag, ADR_O, held);
                    end
                end
                wait_cnt++;
                if (wait_cnt >= period) begin
                    wait_cnt = 0;
                    have_held = 1'b0;
                    n_cmp++;
                    if (exp_adr_q.size() == 0) begin
                        n_err++;
                        $display("FAIL %s adr_queue: got read at %h required no read", tag, ADR_O);
                        exp = ADR_O;
                    end else begin
                        exp = exp_adr_q.pop_front();
                        if (ADR_O !== exp) begin
                            n_err++;
                            $display("FAIL %s adr_word%0d: got %h required %h", tag, acks, ADR_O, exp);
                        end
                    end
                    ACK_I = 1'b1;
                    DAT_I = exp[15:0];
                    acks++;
                end else begin
                    held = ADR_O;
                    have_held = 1'b1;
                end
            end
        end
        n_cmp++;
        if (acks < n) begin
            n_err++;
            $display("FAIL %s ack_timeout: got %0d acks required %0d", tag, acks, n);
        end
        @(negedge clk);
        ACK_I = 1'b0;
        if (done) begin
            n_cmp++;
            if (CYC_O !== 1'b0 || STB_O !== 1'b0) begin
                n_err++;
                $display("FAIL %s burst_end: got cyc=%b stb=%b required 0/0", tag, CYC_O, STB_O);
            end
        end
    endtask

    // Read the display bank: words 0..WPL-1 then two out-of-range addresses
    // that must read 0; data checked one cycle after the address.
    task automatic read_line(input logic [AW-1:0] base, input string tag);
        logic [LAW-1:0] addrs [WPL+2];
        logic [AW-1:0]  a;
        logic [15:0]    exp;
        for (int i = 0; i < WPL; i++) begin
            addrs[i] = LAW'(i);
        end
        addrs[WPL]   = LAW'(WPL);
        addrs[WPL+1] = '1;
        for (int i = 0; i <= WPL + 2; i++) begin
            @(negedge clk);
            if (i > 0) begin
                exp = exp_lb_q.pop_front();
                n_cmp++;
                if (LB_DAT_O !== exp) begin
                    n_err++;
                    $display("FAIL %s lb_read%0d: got %h required %h", tag, i - 1, LB_DAT_O, exp);
                end
            end
            if (i < WPL + 2) begin
                LB_ADR_I = addrs[i];
                a = base + AW'(i);
                exp_lb_q.push_back((i < WPL) ? a[15:0] : 16'h0000);
            end
        end
    endtask

    task automatic test_reset();
        RST_I = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp += 5;
        if (CYC_O !== 1'b0)      begin n_err++; $display("FAIL reset_cyc: got %b required 0", CYC_O); end
        if (STB_O !== 1'b0)      begin n_err++; $display("FAIL reset_stb: got %b required 0", STB_O); end
        if (ADR_O !== '0)        begin n_err++; $display("FAIL reset_adr: got %h required 0", ADR_O); end
        if (UNDERRUN_O !== 1'b0) begin n_err++; $display("FAIL reset_underrun: got %b required 0", UNDERRUN_O); end
        if (LB_DAT_O !== 16'h0)  begin n_err++; $display("FAIL reset_lbdat: got %h required 0", LB_DAT_O); end
        RST_I = 1'b0;
    endtask

    task automatic test_basic_line();
        FB_BASE_I = 23'h001000;
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        n_cmp++;
        if (CYC_O !== 1'b1 || ADR_O !== 23'h001000) begin
            n_err++;
            $display("FAIL basic_start: got cyc=%b adr=%h required 1/001000", CYC_O, ADR_O);
        end
        exp_adr_q.delete();
        push_adrs(23'h001000, WPL);
        run_fetch(WPL, 1, 1'b1, "basic");
        // Stray acknowledges while idle must not move anything.
        repeat (3) begin
            @(negedge clk);
            ACK_I = 1'b1;
        end
        @(negedge clk);
        ACK_I = 1'b0;
        n_cmp++;
        if (CYC_O !== 1'b0 || ADR_O !== 23'h001028) begin
            n_err++;
            $display("FAIL idle_ack: got cyc=%b adr=%h required 0/001028", CYC_O, ADR_O);
        end
        // Second line starts; the first line is now in the display bank.
        pulse(1'b0, 1'b1);
        n_cmp++;
        if (CYC_O !== 1'b1 || ADR_O !== 23'h001028) begin
            n_err++;
            $display("FAIL line2_start: got cyc=%b adr=%h required 1/001028", CYC_O, ADR_O);
        end
        read_line(23'h001000, "basic");
    endtask

    task automatic test_wait_states();
        exp_adr_q.delete();
        push_adrs(23'h001028, WPL);
        run_fetch(WPL, 3, 1'b1, "waitst");
        pulse(1'b0, 1'b1);
        n_cmp++;
        if (ADR_O !== 23'h001050) begin
            n_err++;
            $display("FAIL waitst_next: got %h required 001050", ADR_O);
        end
        read_line(23'h001028, "waitst");
    endtask

    task automatic test_underrun();
        FB_BASE_I = 23'h001000;
        pulse(1'b1, 1'b0);
        n_cmp++;
        if (CYC_O !== 1'b0) begin
            n_err++;
            $display("FAIL vstart_abort: got cyc=%b required 0", CYC_O);
        end
        pulse(1'b0, 1'b1);
        exp_adr_q.delete();
        push_adrs(23'h001000, 10);
        run_fetch(10, 1, 1'b0, "underrun");
        repeat (3) @(negedge clk);
        pulse(1'b0, 1'b1);
        n_cmp += 3;
        if (UNDERRUN_O !== 1'b1) begin n_err++; $display("FAIL underrun_flag: got %b required 1", UNDERRUN_O); end
        if (CYC_O !== 1'b1)      begin n_err++; $display("FAIL underrun_cyc: got %b required 1", CYC_O); end
        if (ADR_O !== 23'h001028) begin n_err++; $display("FAIL underrun_adr: got %h required 001028", ADR_O); end
        exp_adr_q.delete();
        push_adrs(23'h001028, 3);
        run_fetch(3, 2, 1'b0, "underrun_restart");
        n_cmp++;
        if (UNDERRUN_O !== 1'b1) begin
            n_err++;
            $display("FAIL underrun_sticky: got %b required 1", UNDERRUN_O);
        end
        pulse(1'b1, 1'b0);
        n_cmp++;
        if (UNDERRUN_O !== 1'b0 || CYC_O !== 1'b0) begin
            n_err++;
            $display("FAIL underrun_clear: got flag=%b cyc=%b required 0/0", UNDERRUN_O, CYC_O);
        end
    endtask

    task automatic test_simultaneous();
        FB_BASE_I = 23'h002050;
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        exp_adr_q.delete();
        push_adrs(23'h002050, 5);
        run_fetch(5, 1, 1'b0, "simul_pre");
        FB_BASE_I = 23'h003000;
        pulse(1'b1, 1'b1);
        n_cmp++;
        if (ADR_O !== 23'h003000 || CYC_O !== 1'b1 || UNDERRUN_O !== 1'b0) begin
            n_err++;
            $display("FAIL simul_start: got adr=%h cyc=%b urun=%b required 003000/1/0", ADR_O, CYC_O, UNDERRUN_O);
        end
        exp_adr_q.delete();
        push_adrs(23'h003000, WPL);
        run_fetch(WPL, 1, 1'b1, "simul");
    endtask

    task automatic test_wrap();
        FB_BASE_I = 23'h7FFFF0;
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        exp_adr_q.delete();
        push_adrs(23'h7FFFF0, WPL);
        run_fetch(WPL, 2, 1'b1, "wrap");
        n_cmp++;
        if (ADR_O !== 23'h000018) begin
            n_err++;
            $display("FAIL wrap_next: got %h required 000018", ADR_O);
        end
    endtask

`ifdef MGIA_FETCH_DOUBLESCAN_EN
    task automatic test_doublescan();
        int bursts;
        bit cyc_prev;
        FB_BASE_I = 23'h004000;
        bursts = 0;
        exp_adr_q.delete();
        pulse(1'b1, 1'b0);
        for (int p = 1; p <= 4; p++) begin
            cyc_prev = 1'b0;
            if (p == 1) push_adrs(23'h004000, WPL);
            if (p == 3) push_adrs(23'h004028, WPL);
            pulse(1'b0, 1'b1);
            if (CYC_O) begin
                bursts++;
                run_fetch(WPL, 1, 1'b1, "dscan");
            end else begin
                repeat (4) begin
                    @(negedge clk);
                    cyc_prev = cyc_prev | CYC_O;
                end
                if (cyc_prev) bursts++;
            end
            if (p >= 3) read_line(23'h004000, "dscan_show");
        end
        n_cmp++;
        if (bursts != 2) begin
            n_err++;
            $display("FAIL dscan_bursts: got %0d required 2", bursts);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef MGIA_FETCH_DOUBLESCAN_EN
        test_doublescan();
`else
        test_basic_line();
        test_wait_states();
        test_underrun();
        test_simultaneous();
        test_wrap();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
